// File: rtl/imm_ext_pipe.sv
// imm_ext_pipe -- pipelined, parametrised immediate extender.
//
// Widens an IN_W-bit immediate to OUT_W bits in one of four modes:
//   00 ZERO  : zero-extend
//   01 SIGN  : sign-extend
//   10 SSHL  : sign-extend, then shift left by SHAMT
//   11 UPPER : place the immediate in the top IN_W bits, zero below
// Stage S1 holds the raw immediate and mode. Stage S2 holds the extended
// result. Both stages use a valid/ready handshake with full back-pressure.
// The block sits between instruction decode and the ALU operand mux.
//
// Ports
//   clock     in   1      rising-edge clock
//   reset     in   1      synchronous, active-high; empties both stages
//   in_valid  in   1      upstream offers in_imm / in_mode
//   in_ready  out  1      block accepts an item this cycle
//   in_imm    in   IN_W   raw immediate field
//   in_mode   in   2      extension mode (see above)
//   out_valid out  1      out_data / out_neg are valid
//   out_ready in   1      downstream takes out_data this cycle
//   out_data  out  OUT_W  extended immediate
//   out_neg   out  1      MSB of out_data (two's complement sign)
module imm_ext_pipe #(
  parameter int IN_W  = 17,
  parameter int OUT_W = 32,
  parameter int SHAMT = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_neg
);

  localparam logic [1:0] MODE_ZERO  = 2'b00;
  localparam logic [1:0] MODE_SIGN  = 2'b01;
  localparam logic [1:0] MODE_SSHL  = 2'b10;
  localparam logic [1:0] MODE_UPPER = 2'b11;
  localparam int         PAD_W      = OUT_W - IN_W;

  // Reject parameter sets for which the extension cannot be formed.
  generate
    if ((IN_W < 1) || (IN_W >= OUT_W) || (IN_W + SHAMT > OUT_W)) begin : g_bad_params
      $error("imm_ext_pipe: illegal parameters (need 1 <= IN_W < OUT_W and IN_W+SHAMT <= OUT_W)");
    end
  endgenerate

  // Extension of one immediate in the requested mode.
  function automatic logic [OUT_W-1:0] extend(input logic [IN_W-1:0] x,
                                              input logic [1:0]      mode);
    logic [OUT_W-1:0] sx;
    sx = {{PAD_W{x[IN_W-1]}}, x};
    case (mode)
      MODE_ZERO:  extend = {{PAD_W{1'b0}}, x};
      MODE_SIGN:  extend = sx;
      MODE_SSHL:  extend = sx << SHAMT;
      MODE_UPPER: extend = {x, {PAD_W{1'b0}}};
      default:    extend = {OUT_W{1'b0}};
    endcase
  endfunction

  logic             s1_v_r;
  logic [IN_W-1:0]  s1_imm_r;
  logic [1:0]       s1_mode_r;
  logic             s2_v_r;

  logic             s1_adv_s;
  logic             s2_adv_s;
  logic [OUT_W-1:0] ext_s;

  // Stall chain and S1->S2 datapath; in_ready depends only on state and out_ready.
  always_comb begin
    s2_adv_s = !s2_v_r || out_ready;
    s1_adv_s = !s1_v_r || s2_adv_s;
    ext_s    = extend(s1_imm_r, s1_mode_r);
  end

  assign in_ready  = s1_adv_s;
  assign out_valid = s2_v_r;

  // Pipeline registers; data only loads when a valid item moves in, so an
  // empty S2 keeps its last result on out_data.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_v_r    <= 1'b0;
      s1_imm_r  <= {IN_W{1'b0}};
      s1_mode_r <= 2'b00;
      s2_v_r    <= 1'b0;
      out_data  <= {OUT_W{1'b0}};
      out_neg   <= 1'b0;
    end else begin
      if (s1_adv_s) begin
        s1_v_r <= in_valid;
        if (in_valid) begin
          s1_imm_r  <= in_imm;
          s1_mode_r <= in_mode;
        end
      end
      if (s2_adv_s) begin
        s2_v_r <= s1_v_r;
        if (s1_v_r) begin
          out_data <= ext_s;
          out_neg  <= ext_s[OUT_W-1];
        end
      end
    end
  end

endmodule

// File: tb/tb_imm_ext_pipe.sv
module tb_imm_ext_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  // default-parameter instance (17 -> 32, shift 2)
  logic        in_valid, in_ready, out_valid, out_ready, out_neg;
  logic [16:0] in_imm;
  logic [1:0]  in_mode;
  logic [31:0] out_data;
  // narrow instance (12 -> 16, shift 1)
  logic        n_in_valid, n_in_ready, n_out_valid, n_out_ready, n_out_neg;
  logic [11:0] n_in_imm;
  logic [1:0]  n_in_mode;
  logic [15:0] n_out_data;

  imm_ext_pipe dut (
    .clock(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_neg(out_neg)
  );

  imm_ext_pipe #(.IN_W(12), .OUT_W(16), .SHAMT(1)) dut_n (
    .clock(clk), .reset(reset),
    .in_valid(n_in_valid), .in_ready(n_in_ready), .in_imm(n_in_imm), .in_mode(n_in_mode),
    .out_valid(n_out_valid), .out_ready(n_out_ready), .out_data(n_out_data), .out_neg(n_out_neg)
  );

  logic [31:0] exp_q[$];
  logic [15:0] n_exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  // Arithmetic reference model of the extension.
  function automatic longint model(longint x, int mode, int in_w, int out_w, int shamt);
    longint mask, v;
    mask = (longint'(1) << out_w) - 1;
    v = x;
    if (((x >> (in_w - 1)) & 1) == 1) v = x - (longint'(1) << in_w);
    case (mode)
      0:       model = x & mask;
      1:       model = v & mask;
      2:       model = (v * (longint'(1) << shamt)) & mask;
      default: model = (x << (out_w - in_w)) & mask;
    endcase
  endfunction

  task automatic test_reset;
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || out_neg !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid=%b data=%h neg=%b, want 0/00000000/0", out_valid, out_data, out_neg);
    end
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    n_tests++;
    if (n_out_valid !== 1'b0 || n_out_data !== 16'h0 || n_in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_narrow: got valid=%b data=%h rdy=%b want 0/0000/1", n_out_valid, n_out_data, n_in_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_latency;
    in_valid = 1'b1; in_imm = 17'h1FFFF; in_mode = 2'b01; out_ready = 1'b1;
    #1;
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL lat_accept: in_ready got %b want 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL lat_edge1: out_valid got %b want 0", out_valid);
    end
    @(negedge clk);
    #1;
    n_tests++;
    if (out_valid !== 1'b1 || out_data !== 32'hFFFFFFFF || out_neg !== 1'b1) begin
      n_fail++;
      $display("FAIL lat_edge2: got valid=%b data=%h neg=%b want 1/ffffffff/1", out_valid, out_data, out_neg);
    end
    @(negedge clk);
  endtask

  task automatic test_modes;
    logic [16:0] imms [4];
    logic [1:0]  mods [4];
    logic [31:0] exps [4];
    logic [31:0] e;
    int idx, outs;
    imms = '{17'h1FFFF, 17'h00001, 17'h10000, 17'h00003};
    mods = '{2'b00, 2'b11, 2'b10, 2'b10};
    exps = '{32'h0001FFFF, 32'h00008000, 32'hFFFC0000, 32'h0000000C};
    idx = 0; outs = 0;
    for (int c = 0; c < 12; c++) begin
      in_valid = (idx < 4);
      if (idx < 4) begin in_imm = imms[idx]; in_mode = mods[idx]; end
      out_ready = 1'b1;
      #1;
      if (in_valid && in_ready) begin exp_q.push_back(exps[idx]); idx++; end
      if (out_valid && out_ready) begin
        n_tests++; outs++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL modes_extra: unexpected out_data=%h", out_data);
        end else begin
          e = exp_q.pop_front();
          if (out_data !== e || out_neg !== e[31]) begin
            n_fail++;
            $display("FAIL modes_data: got %h neg=%b want %h neg=%b", out_data, out_neg, e, e[31]);
          end
        end
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    n_tests++;
    if (outs != 4) begin
      n_fail++;
      $display("FAIL modes_count: got %0d outputs want 4", outs);
    end
  endtask

  task automatic test_backpressure;
    logic [16:0] imms [4];
    logic [31:0] e;
    int idx, outs;
    imms = '{17'h00005, 17'h1FFF0, 17'h0ABCD, 17'h10001};
    idx = 0; outs = 0;
    for (int c = 0; c < 6; c++) begin
      in_valid = 1'b1; in_imm = imms[idx]; in_mode = 2'b01; out_ready = 1'b0;
      #1;
      if (c >= 2) begin
        n_tests++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== exp_q[0]) begin
          n_fail++;
          $display("FAIL bp_hold: got valid=%b rdy=%b data=%h want 1/0/%h", out_valid, in_ready, out_data, exp_q[0]);
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(32'(model(longint'(imms[idx]), 1, 17, 32, 2)));
        idx++;
      end
      @(negedge clk);
    end
    n_tests++;
    if (idx != 2) begin
      n_fail++;
      $display("FAIL bp_accepted: got %0d accepted want 2", idx);
    end
    for (int c = 0; c < 10; c++) begin
      in_valid = (idx < 4);
      if (idx < 4) in_imm = imms[idx];
      out_ready = 1'b1;
      #1;
      if (c < 4) begin
        n_tests++;
        if (out_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL bp_bubble: cycle %0d out_valid got %b want 1", c, out_valid);
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(32'(model(longint'(imms[idx]), 1, 17, 32, 2)));
        idx++;
      end
      if (out_valid && out_ready) begin
        n_tests++; outs++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL bp_extra: unexpected out_data=%h", out_data);
        end else begin
          e = exp_q.pop_front();
          if (out_data !== e) begin
            n_fail++;
            $display("FAIL bp_order: got %h want %h", out_data, e);
          end
        end
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    n_tests++;
    if (outs != 4 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL bp_drain: got %0d outputs, %0d left want 4/0", outs, exp_q.size());
    end
  endtask

  task automatic test_reset_mid;
    for (int c = 0; c < 2; c++) begin
      in_valid = 1'b1; in_imm = 17'(c + 100); in_mode = 2'b00; out_ready = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_mid: got valid=%b rdy=%b data=%h want 0/1/00000000", out_valid, in_ready, out_data);
    end
    @(negedge clk);
    in_valid = 1'b1; in_imm = 17'h00007; in_mode = 2'b01; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_lat1: out_valid got %b want 0", out_valid);
    end
    @(negedge clk);
    #1;
    n_tests++;
    if (out_valid !== 1'b1 || out_data !== 32'h00000007) begin
      n_fail++;
      $display("FAIL rst_mid_item: got valid=%b data=%h want 1/00000007", out_valid, out_data);
    end
    @(negedge clk);
  endtask

  task automatic test_random;
    logic [16:0] cur_imm;
    logic [1:0]  cur_mode;
    logic [31:0] e;
    bit pending;
    int sent, c;
    pending = 1'b0; sent = 0; c = 0;
    cur_imm = 17'h0; cur_mode = 2'b00;
    while ((sent < 40 || exp_q.size() != 0) && c < 400) begin
      if (!pending && sent < 40 && ($urandom_range(3) != 0)) begin
        pending = 1'b1;
        cur_imm = 17'($urandom);
        cur_mode = 2'($urandom_range(3));
      end
      in_valid = pending; in_imm = cur_imm; in_mode = cur_mode;
      out_ready = ($urandom_range(2) != 0);
      #1;
      if (in_valid && in_ready) begin
        exp_q.push_back(32'(model(longint'(cur_imm), int'(cur_mode), 17, 32, 2)));
        pending = 1'b0; sent++;
      end
      if (out_valid && out_ready) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL rand_extra: unexpected out_data=%h", out_data);
        end else begin
          e = exp_q.pop_front();
          if (out_data !== e || out_neg !== e[31]) begin
            n_fail++;
            $display("FAIL rand_data: got %h neg=%b want %h neg=%b", out_data, out_neg, e, e[31]);
          end
        end
      end
      @(negedge clk);
      c++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n_tests++;
    if (sent != 40 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL rand_timeout: sent %0d left %0d want 40/0", sent, exp_q.size());
    end
  endtask

  task automatic test_narrow;
    logic [11:0] imms [4];
    logic [1:0]  mods [4];
    logic [15:0] exps [4];
    logic [15:0] e;
    int idx, outs;
    imms = '{12'h800, 12'h800, 12'h7FF, 12'h123};
    mods = '{2'b01, 2'b10, 2'b10, 2'b11};
    exps = '{16'hF800, 16'hF000, 16'h0FFE, 16'h1230};
    idx = 0; outs = 0;
    for (int c = 0; c < 12; c++) begin
      n_in_valid = (idx < 4);
      if (idx < 4) begin n_in_imm = imms[idx]; n_in_mode = mods[idx]; end
      n_out_ready = 1'b1;
      #1;
      if (n_in_valid && n_in_ready) begin n_exp_q.push_back(exps[idx]); idx++; end
      if (n_out_valid && n_out_ready) begin
        n_tests++; outs++;
        if (n_exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL narrow_extra: unexpected out_data=%h", n_out_data);
        end else begin
          e = n_exp_q.pop_front();
          if (n_out_data !== e || n_out_neg !== e[15]) begin
            n_fail++;
            $display("FAIL narrow_data: got %h neg=%b want %h neg=%b", n_out_data, n_out_neg, e, e[15]);
          end
        end
      end
      @(negedge clk);
    end
    n_in_valid = 1'b0;
    n_tests++;
    if (outs != 4) begin
      n_fail++;
      $display("FAIL narrow_count: got %0d outputs want 4", outs);
    end
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0; in_imm = 17'h0; in_mode = 2'b00; out_ready = 1'b1;
    n_in_valid = 1'b0; n_in_imm = 12'h0; n_in_mode = 2'b00; n_out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_latency();
    test_modes();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_narrow();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
